proc_in_fifo: RTL and testbench
===============================

# proc_in_fifo

Buffered input-port adapter that feeds processor input port 0 (`proc_io_in` / `proc_req_in`) of the procTest_00 filter processor. It accepts signed 32-bit samples from an upstream valid/ready source (ADC or sample generator) and presents them first-word-fall-through to the processor. Each `proc_req_in` pulse consumes one word. The block also flags when a full FFT frame is buffered, and records underflow when the processor reads from an empty buffer.

## Interface
Parameters:
- `DATA_W`, 32: sample width, two's complement.
- `DEPTH`, 16: total capacity in words, including the output register; power of two, ≥ 4.
- `FRAME_LEN`, 8: `frame_ready` threshold; 1 ≤ FRAME_LEN ≤ DEPTH.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  DATA_W  upstream sample (signed).
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  block can accept; `count < DEPTH`.
- `proc_req_in`  in  1  processor read strobe; a pop occurs on each rising edge where it is high.
- `proc_io_in`  out  DATA_W  current front word (registered).
- `count`  out  $clog2(DEPTH)+1  words held.
- `frame_ready`  out  1  `count >= FRAME_LEN`.
- `underflow`  out  1  sticky; set when a read hits an empty buffer.
- `err_clr`  in  1  clears `underflow`.

## Operation
- Reset values: `proc_io_in`=0, `count`=0, `s_ready`=1, `frame_ready`=0, `underflow`=0. Pointers return to 0 and stored data is discarded.
- Push: occurs when `s_valid && s_ready`. `s_ready` depends only on `count`; there is no combinational path from `proc_req_in` to `s_ready`.
- Pop: occurs when `proc_req_in && count != 0`.
  - The output register loads the next stored word.
  - If no stored word remains, the output register holds its value.
- Write to an empty buffer: the word goes directly into the output register.
- Simultaneous push and pop:
  - `count` is unchanged.
  - If `count == 1`, the pushed word goes directly to the output register.
  - When full, a push is not possible in that cycle because `s_ready = 0`.
- Underflow: `proc_req_in` with `count == 0` sets `underflow`.
  - `proc_io_in` keeps the last delivered value.
  - `count` stays 0.
- `err_clr`: clears `underflow`. If an underflow and `err_clr` occur in the same cycle, the set wins.
- Storage and pointers:
  - Storage ring holds DEPTH-1 words plus the output register.
  - Read and write pointers wrap modulo DEPTH-1 storage slots; the pointer logic must handle the non-power-of-two slot count.
- `frame_ready` and `s_ready` are combinational from the registered `count`.

## Timing
- Push-to-visible latency on an empty buffer: a word accepted at edge N appears on `proc_io_in` after edge N, i.e. readable in cycle N+1.
- Pop latency: the next word appears on `proc_io_in` immediately after the pop edge, enabling back-to-back reads each cycle.
- `count` updates on the same edge as the push or pop that changes it.
- `rst` has priority over all other inputs. Asserting it mid-stream drops all held words; `s_ready` returns to 1 in the cycle after reset is sampled.
- The processor samples `proc_io_in` in the cycle it raises `proc_req_in`; the word present in that cycle is the one consumed.

## Structure
- Shared package `proc_io_pkg`:
  - `PROC_DATA_W` = 32.
  - `sample_t` (signed [31:0]).
  - Input/output port-number constants: port 0 = input, port 1 (`out_en == 2`) = output.
- Sub-module `proc_in_fifo_mem`: DEPTH-1 × DATA_W storage with one write port and one asynchronous-read port.
- Pointer, count, output-register and flag logic live in the top module.

## Test plan
- Reset, then push 5, −3, 7 at one per cycle with no requests → `count`=3, `proc_io_in`=5, `frame_ready`=0. Three consecutive `proc_req_in` pulses deliver 5, −3, 7, then `count`=0.
- Push 16 words (0..15) with no reads → `s_ready`=0 after the 16th push, and a 17th push with `s_valid`=1 is ignored. Then 16 reads return 0..15 in order.
- With `count`=1 (value 9), push 10 and pop in the same cycle → `count` stays 1 and `proc_io_in`=10.
- Read from empty after last value 42 → `underflow`=1, `proc_io_in`=42, `count`=0. `err_clr` for one cycle → `underflow`=0.
- Push 8 words with `FRAME_LEN`=8 → `frame_ready` rises on the edge of the 8th push. One pop → `frame_ready`=0.
- Assert `rst` with `count`=6 → next cycle `count`=0, `proc_io_in`=0, `s_ready`=1. A subsequent push of 123 appears on `proc_io_in` one cycle later.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared definitions for the procTest_00 processor I/O adapters.
package proc_io_pkg;

    localparam int unsigned PROC_DATA_W = 32;

    typedef logic signed [PROC_DATA_W-1:0] sample_t;

    // Processor port numbering; the output port is selected with out_en == 2.
    typedef enum logic [1:0] {
        PROC_PORT_IN  = 2'd0,
        PROC_PORT_OUT = 2'd1
    } proc_port_t;

    localparam logic [1:0] PROC_OUT_EN = 2'd2;

endpackage

// File: rtl/proc_in_fifo_mem.sv
// Storage ring for proc_in_fifo: one synchronous write port, one asynchronous read port.
module proc_in_fifo_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SLOTS  = 15,
    parameter int unsigned ADDR_W = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [SLOTS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// First-word-fall-through input buffer feeding processor input port 0,
// with frame-ready and sticky underflow flags.
module proc_in_fifo
    import proc_io_pkg::*;
#(
    parameter int unsigned DATA_W    = PROC_DATA_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       proc_req_in,
    output logic [DATA_W-1:0]          proc_io_in,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       frame_ready,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int unsigned SLOTS = DEPTH - 1;
    localparam int unsigned PTR_W = $clog2(SLOTS);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [DATA_W-1:0] r_out;
    logic              r_underflow;

    logic              w_empty;
    logic              w_one;
    logic              w_push;
    logic              w_pop;
    logic              w_mem_we;
    logic              w_mem_rd;
    logic              w_bypass;
    logic [DATA_W-1:0] w_rdata;

    // Slot count is DEPTH-1 (not a power of two), so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_empty  = (r_count == '0);
        w_one    = (r_count == CNT_W'(1));
        w_push   = s_valid && s_ready;
        w_pop    = proc_req_in && !w_empty;
        // The output register counts as one word; the ring holds the rest.
        w_bypass = w_push && (w_empty || (w_pop && w_one));
        w_mem_we = w_push && !w_bypass;
        w_mem_rd = w_pop && !w_one;
    end

    proc_in_fifo_mem #(
        .DATA_W (DATA_W),
        .SLOTS  (SLOTS),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wptr),
        .i_wdata (s_data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_out       <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_mem_rd) begin
                r_rptr <= next_ptr(r_rptr);
                r_out  <= w_rdata;
            end else if (w_bypass) begin
                r_out  <= s_data;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (proc_req_in && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    always_comb begin
        s_ready     = (r_count < CNT_W'(DEPTH));
        frame_ready = (r_count >= CNT_W'(FRAME_LEN));
        count       = r_count;
        proc_io_in  = r_out;
        underflow   = r_underflow;
    end

endmodule

// File: tb/tb_proc_in_fifo.sv
// Scoreboard bench for proc_in_fifo: accepted pushes queue expected words,
// a negedge monitor checks every consumed word.
module tb_proc_in_fifo;
    import proc_io_pkg::*;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned FRAME_LEN = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DATA_W-1:0]     s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  proc_req_in;
    logic [DATA_W-1:0]     proc_io_in;
    logic [$clog2(DEPTH):0] count;
    logic                  frame_ready;
    logic                  underflow;
    logic                  err_clr;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [DATA_W-1:0] exp_q [$];

    proc_in_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .proc_req_in (proc_req_in),
        .proc_io_in  (proc_io_in),
        .count       (count),
        .frame_ready (frame_ready),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one push; expected words are queued only when acceptance is intended.
    task automatic push(input logic [DATA_W-1:0] v, input bit accept);
        s_data  = v;
        s_valid = 1'b1;
        if (accept) exp_q.push_back(v);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic pops(input int unsigned n);
        proc_req_in = 1'b1;
        for (int unsigned i = 0; i < n; i++) tick();
        proc_req_in = 1'b0;
    endtask

    // Monitor: a word is consumed on each edge where a request meets a non-empty buffer.
    always @(negedge clk) begin
        if (!rst && proc_req_in && count != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL consume: got %0d with empty scoreboard", proc_io_in);
            end else begin
                check("consume", proc_io_in, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; proc_req_in = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_out", proc_io_in, 0);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_frame", 32'(frame_ready), 0);
        check("rst_underflow", 32'(underflow), 0);

        // Three pushes, then three back-to-back reads
        s_valid = 1'b1;
        s_data = 32'd5;        exp_q.push_back(s_data); tick();
        s_data = -32'sd3;      exp_q.push_back(s_data); tick();
        s_data = 32'd7;        exp_q.push_back(s_data); tick();
        s_valid = 1'b0;
        check("three_count", 32'(count), 3);
        check("three_front", proc_io_in, 5);
        check("three_frame", 32'(frame_ready), 0);
        pops(3);
        check("three_drained", 32'(count), 0);

        // Fill to capacity, ignored extra push, drain in order
        for (int unsigned i = 0; i < DEPTH; i++) push(32'(i), 1'b1);
        check("full_s_ready", 32'(s_ready), 0);
        check("full_count", 32'(count), DEPTH);
        check("full_frame", 32'(frame_ready), 1);
        push(32'd99, 1'b0);
        check("full_ignored_count", 32'(count), DEPTH);
        pops(DEPTH);
        check("full_drained", 32'(count), 0);
        check("full_no_underflow", 32'(underflow), 0);

        // Simultaneous push and pop with one word held
        push(32'd9, 1'b1);
        check("one_front", proc_io_in, 9);
        s_data = 32'd10; s_valid = 1'b1; proc_req_in = 1'b1; exp_q.push_back(s_data);
        tick();
        s_valid = 1'b0; proc_req_in = 1'b0;
        check("swap_count", 32'(count), 1);
        check("swap_front", proc_io_in, 10);
        pops(1);

        // Underflow keeps last value; clear; set wins over clear
        push(32'd42, 1'b1);
        pops(1);
        pops(1);
        check("uf_flag", 32'(underflow), 1);
        check("uf_out", proc_io_in, 42);
        check("uf_count", 32'(count), 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("uf_clear", 32'(underflow), 0);
        err_clr = 1'b1; proc_req_in = 1'b1; tick(); err_clr = 1'b0; proc_req_in = 1'b0;
        check("uf_set_wins", 32'(underflow), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("uf_clear2", 32'(underflow), 0);

        // Frame threshold
        for (int unsigned i = 0; i < FRAME_LEN - 1; i++) push(32'(100 + i), 1'b1);
        check("frame_below", 32'(frame_ready), 0);
        push(32'(100 + FRAME_LEN - 1), 1'b1);
        check("frame_at", 32'(frame_ready), 1);
        check("frame_count", 32'(count), FRAME_LEN);
        pops(1);
        check("frame_after_pop", 32'(frame_ready), 0);

        // Mid-stream reset with six words held
        pops(1);
        check("pre_rst_count", 32'(count), 6);
        rst = 1'b1; tick(); rst = 1'b0;
        exp_q.delete();
        check("mrst_count", 32'(count), 0);
        check("mrst_out", proc_io_in, 0);
        check("mrst_s_ready", 32'(s_ready), 1);
        push(32'd123, 1'b1);
        check("mrst_push_out", proc_io_in, 123);
        check("mrst_push_count", 32'(count), 1);
        pops(1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
